up_counter_sequencer: RTL
=========================

# up_counter_sequencer

Run controller for the 3-bit posedge up counter. It accepts start requests through a req/ack handshake and latches a terminal count. It then advances the counter once every PRESCALE clocks, honouring pause and abort, and signals completion with a one-cycle done pulse. It sits between software-facing control logic and the counter datapath, and is the only block that sequences the counter.

## Interface
Parameters:
- PRESCALE, default 1: clocks per count step; legal range 1..16.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- not_RST  in  1  reset; asynchronous, active-low.
- start_req  in  1  run request; requester holds it high until start_ack.
- limit  in  3  terminal count; sampled only on the accepting edge.
- pause  in  1  level; freezes counting while high.
- abort  in  1  level; terminates a run without done.
- start_ack  out  1  one-cycle pulse on the accepting edge.
- busy  out  1  high from acceptance until the run ends.
- paused  out  1  high while in HOLD.
- done  out  1  one-cycle pulse at normal run completion.
- Q0, Q1, Q2  out  1 each  current count, LSB first.

## Operation
- FSM states:
  - IDLE: waiting for a request.
  - RUN: counting.
  - HOLD: paused.
- Registered state: limit_r[2:0], presc[3:0], count[2:0]. All outputs are registered.
- IDLE:
  - If start_req=1, go to RUN on the next edge.
  - On that edge: start_ack=1, busy=1, count=0, presc=0, limit_r=limit.
  - If start_req=0, nothing changes and count holds its last value.
- RUN:
  - tick = (presc==PRESCALE-1) and pause=0.
  - On a tick, presc goes to 0. Otherwise presc increments, unless pause=1.
  - On a tick with count!=limit_r, count increments by 1.
  - On a tick with count==limit_r: go to IDLE, done=1, busy=0, count holds at limit_r.
- pause=1 in RUN: go to HOLD on the next edge, with presc frozen and paused=1.
- HOLD: when pause=0, return to RUN and resume from the frozen presc value. No count is lost or duplicated.
- abort=1 in RUN or HOLD: go to IDLE on the next edge with busy=0 and paused=0. No done pulse. count holds.
- Priority: abort > terminal tick > pause > normal tick.
- start_req while busy: ignored, no ack.
- limit=0: the run lasts PRESCALE clocks with count=0, then done.
- limit=7: count reaches 7 and the run ends. It never wraps to 0 inside a run.

## Timing
- Reset values: state=IDLE, count=0 (Q0=Q1=Q2=0), presc=0, limit_r=0, start_ack=0, busy=0, paused=0, done=0.
- Reset is honoured mid-run, asynchronously.
- Let e0 be the accepting edge, with P=PRESCALE and no pause:
  - count=k holds from e0+k·P.
  - done=1 and busy=0 at edge e0+(limit+1)·P, for one cycle.
- Earliest next acceptance: the edge after done.
- start_ack and done are exactly one cycle wide.
- Pause adds exactly the number of cycles spent in HOLD, plus one entry cycle.

## Configuration
- Macro: UP_COUNTER_SEQ_AUTO_RELOAD_EN.
- When defined:
  - A terminal tick pulses done, sets count=0, keeps busy=1 and stays in RUN.
  - This repeats until abort, which is the only exit.
- When undefined: behaviour exactly as in Operation (single run).

## Structure
- Package up_counter_seq_pkg holds:
  - the state enum typedef (IDLE, RUN, HOLD);
  - localparam CNT_W=3;
  - localparam PRESC_W=4.
- Sub-module up_counter_seq_prescaler holds the presc register and tick generation. Its inputs are enable, clear and freeze; its output is tick.
- The FSM, count and handshake logic live in the top module.

## Test plan
- Reset mid-run: drive not_RST low asynchronously between edges at count=3 -> all outputs 0 immediately, state IDLE.
- Basic run, PRESCALE=1, limit=5: start_req -> start_ack at e0; count 0..5 on consecutive edges; done at e0+6; busy=0 at e0+6.
- PRESCALE=2, limit=0: done exactly 2 edges after ack; count stays 0; then a second start_req is accepted on the following edge.
- Pause for 4 cycles at count=2, PRESCALE=3 -> paused=1; count frozen at 2; done delayed by exactly 5 cycles versus the unpaused run.
- Abort on the same edge as the terminal tick, limit=3 -> no done; busy=0; count=3; a start_req held during the run gets no ack until IDLE.
- With UP_COUNTER_SEQ_AUTO_RELOAD_EN defined, limit=7: count wraps 7->0; done pulses every 8·PRESCALE cycles; busy stays 1 until abort.

Source files
------------

// File: rtl/up_counter_seq_pkg.sv
// -----------------------------------------------------------------------------
// up_counter_seq_pkg
//
// Shared definitions for the up-counter run controller:
//   - state_e  : sequencer FSM states (IDLE, RUN, HOLD)
//   - CNT_W    : width of the counter datapath (3 bits, Q0..Q2)
//   - PRESC_W  : width of the prescale counter (PRESCALE up to 16)
//   - is_terminal() : compare helper for the terminal-count condition
// -----------------------------------------------------------------------------
package up_counter_seq_pkg;

  localparam int CNT_W   = 3;
  localparam int PRESC_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  // True when the running count has reached the latched terminal value.
  function automatic logic is_terminal(input logic [CNT_W-1:0] count,
                                       input logic [CNT_W-1:0] limit_r);
    return (count == limit_r);
  endfunction

endpackage : up_counter_seq_pkg

// File: rtl/up_counter_seq_prescaler.sv
// -----------------------------------------------------------------------------
// up_counter_seq_prescaler
//
// Divides the clock down to one count step every PRESCALE clocks. The
// prescale register only advances while enabled and not frozen, so a pause
// keeps the partial step intact and resumes from exactly where it stopped.
//
// Parameters:
//   PRESCALE  clocks per count step, 1..16
//
// Ports:
//   CLK      in   system clock, rising edge
//   not_RST  in   asynchronous active-low reset
//   enable   in   prescaler runs (sequencer is in RUN)
//   clear    in   force the prescale register to zero on the next edge
//   freeze   in   hold the prescale register and suppress tick
//   tick     out  combinational: this cycle completes a count step
// -----------------------------------------------------------------------------
module up_counter_seq_prescaler
  import up_counter_seq_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic CLK,
  input  logic not_RST,
  input  logic enable,
  input  logic clear,
  input  logic freeze,
  output logic tick
);

  localparam logic [PRESC_W-1:0] LAST = PRESC_W'(PRESCALE - 1);

  logic [PRESC_W-1:0] presc_q;
  logic [PRESC_W-1:0] presc_d;
  logic               at_last;
  logic               advance;

  assign at_last = (presc_q == LAST);
  assign advance = enable & ~freeze;
  assign tick    = advance & at_last;

  always_comb begin
    presc_d = presc_q;
    if (clear) begin
      presc_d = '0;
    end else if (advance) begin
      // Wrap on the step boundary; with PRESCALE=1 this keeps presc at 0
      // and every enabled, unfrozen cycle is a tick.
      presc_d = at_last ? '0 : presc_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge not_RST) begin
    if (!not_RST) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

endmodule : up_counter_seq_prescaler

// File: rtl/up_counter_sequencer.sv
// -----------------------------------------------------------------------------
// up_counter_sequencer
//
// Run controller for the 3-bit up counter. A run is requested with a
// start_req/start_ack handshake; the terminal count is latched on the
// accepting edge. The count then advances once every PRESCALE clocks,
// can be paused (HOLD) or aborted, and a normal completion emits a
// single-cycle done pulse. All outputs come straight from flops.
//
// Build option:
//   UP_COUNTER_SEQ_AUTO_RELOAD_EN  when defined, a terminal step pulses done,
//                                  restarts the count at 0 and stays in RUN;
//                                  only abort ends the run.
//
// Parameters:
//   PRESCALE   clocks per count step, 1..16 (default 1)
//
// Ports:
//   CLK        in   system clock, rising edge
//   not_RST    in   asynchronous active-low reset
//   start_req  in   run request, held by the requester until start_ack
//   limit[2:0] in   terminal count, sampled on the accepting edge only
//   pause      in   level, freezes counting while high
//   abort      in   level, ends a run without done
//   start_ack  out  one-cycle pulse on the accepting edge
//   busy       out  high from acceptance until the run ends
//   paused     out  high while in HOLD
//   done       out  one-cycle pulse on normal completion
//   Q0,Q1,Q2   out  current count, LSB first
// -----------------------------------------------------------------------------
module up_counter_sequencer
  import up_counter_seq_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic             CLK,
  input  logic             not_RST,
  input  logic             start_req,
  input  logic [CNT_W-1:0] limit,
  input  logic             pause,
  input  logic             abort,
  output logic             start_ack,
  output logic             busy,
  output logic             paused,
  output logic             done,
  output logic             Q0,
  output logic             Q1,
  output logic             Q2
);

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] limit_q;
  logic [CNT_W-1:0] limit_d;
  logic             ack_q;
  logic             ack_d;
  logic             busy_q;
  logic             busy_d;
  logic             paused_q;
  logic             paused_d;
  logic             done_q;
  logic             done_d;

  logic             tick;
  logic             presc_en;
  logic             presc_clr;

  // The prescaler only runs in RUN. Holding it cleared while idle means the
  // accepting edge always starts a run with presc=0. In HOLD it is simply
  // not enabled, which freezes the partial step.
  assign presc_en  = (state_q == RUN);
  assign presc_clr = (state_q == IDLE);

  up_counter_seq_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .CLK     (CLK),
    .not_RST (not_RST),
    .enable  (presc_en),
    .clear   (presc_clr),
    .freeze  (pause),
    .tick    (tick)
  );

  // Next-state and output decode. Priority inside RUN:
  // abort, then a tick (terminal or not), then pause. A tick can only occur
  // with pause low, so a terminal step is never shadowed by pause.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    limit_d  = limit_q;
    ack_d    = 1'b0;
    done_d   = 1'b0;
    busy_d   = busy_q;
    paused_d = paused_q;

    case (state_q)
      IDLE: begin
        if (start_req) begin
          state_d = RUN;
          ack_d   = 1'b1;
          busy_d  = 1'b1;
          count_d = '0;
          limit_d = limit;
        end
      end

      RUN: begin
        if (abort) begin
          state_d  = IDLE;
          busy_d   = 1'b0;
          paused_d = 1'b0;
        end else if (tick) begin
          if (is_terminal(count_q, limit_q)) begin
            done_d = 1'b1;
`ifdef UP_COUNTER_SEQ_AUTO_RELOAD_EN
            // Continuous mode: restart the count, stay busy in RUN.
            count_d = '0;
`else
            // Single run: the count stays parked at the terminal value.
            state_d = IDLE;
            busy_d  = 1'b0;
`endif
          end else begin
            count_d = count_q + 1'b1;
          end
        end else if (pause) begin
          state_d  = HOLD;
          paused_d = 1'b1;
        end
      end

      HOLD: begin
        if (abort) begin
          state_d  = IDLE;
          busy_d   = 1'b0;
          paused_d = 1'b0;
        end else if (!pause) begin
          // Back to RUN; the prescaler picks up from its frozen value on
          // the following cycle, so no step is lost or repeated.
          state_d  = RUN;
          paused_d = 1'b0;
        end
      end

      default: begin
        state_d  = IDLE;
        busy_d   = 1'b0;
        paused_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge not_RST) begin
    if (!not_RST) begin
      state_q  <= IDLE;
      count_q  <= '0;
      limit_q  <= '0;
      ack_q    <= 1'b0;
      busy_q   <= 1'b0;
      paused_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      limit_q  <= limit_d;
      ack_q    <= ack_d;
      busy_q   <= busy_d;
      paused_q <= paused_d;
      done_q   <= done_d;
    end
  end

  assign start_ack = ack_q;
  assign busy      = busy_q;
  assign paused    = paused_q;
  assign done      = done_q;
  assign Q0        = count_q[0];
  assign Q1        = count_q[1];
  assign Q2        = count_q[2];

endmodule : up_counter_sequencer
